// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide unit: shift-add multiply, restoring divide,
// one bit per clock, with pipeline stall and a one-cycle writeback strobe.
module multdiv_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ctrl_MULT,
  input  logic                      ctrl_DIV,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     data_operandA,
  input  logic [DATA_WIDTH-1:0]     data_operandB,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  output logic [DATA_WIDTH-1:0]     data_result,
  output logic                      data_exception,
  output logic                      data_resultRDY,
  output logic [REG_ADDR_WIDTH-1:0] result_reg,
  output logic                      stall,
  output logic                      busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [W-1:0]              hi_q, hi_d;     // mul: partial product high / div: remainder
  logic [W-1:0]              lo_q, lo_d;     // mul: multiplier / div: dividend -> quotient
  logic [W-1:0]              b_q, b_d;       // mul: multiplicand / div: divisor
  logic                      sign_q, sign_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [W-1:0]              res_q, res_d;
  logic                      exc_q, exc_d;
  logic [REG_ADDR_WIDTH-1:0] rreg_q, rreg_d;

  logic [W-1:0]  mag_a, mag_b;
  logic [W:0]    mul_sum;
  logic [W-1:0]  mul_hi, mul_lo;
  logic [PW-1:0] mul_mag, mul_prod;
  logic          mul_ovf;
  logic [W:0]    div_shift, div_diff;
  logic          div_ok;
  logic [W-1:0]  div_hi, div_lo, div_quot;
  logic          div_ovf;
  logic          last_iter;

  // Operand magnitudes and one iteration of each algorithm
  always_comb begin
    mag_a     = data_operandA[W-1] ? W'(-data_operandA) : data_operandA;
    mag_b     = data_operandB[W-1] ? W'(-data_operandB) : data_operandB;

    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : W'(0))};
    mul_hi    = mul_sum[W:1];
    mul_lo    = {mul_sum[0], lo_q[W-1:1]};
    mul_mag   = {mul_hi, mul_lo};
    mul_prod  = sign_q ? PW'(-mul_mag) : mul_mag;
    mul_ovf   = (mul_prod[PW-1:W-1] != {(W+1){mul_prod[W-1]}});

    div_shift = {hi_q, lo_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = ~div_diff[W];
    div_hi    = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
    div_lo    = {lo_q[W-2:0], div_ok};
    div_quot  = sign_q ? W'(-div_lo) : div_lo;
    // Only a positive quotient of magnitude 2^(W-1) cannot be represented
    div_ovf   = ~sign_q & div_lo[W-1];

    last_iter = (cnt_q == CNT_WIDTH'(W - 1));
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    sign_d  = sign_q;
    dest_d  = dest_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rreg_d  = rreg_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!flush) begin
          if (ctrl_MULT) begin
            hi_d    = '0;
            lo_d    = mag_b;
            b_d     = mag_a;
            sign_d  = data_operandA[W-1] ^ data_operandB[W-1];
            dest_d  = dest_reg;
            state_d = RUN_MUL;
          end else if (ctrl_DIV) begin
            if (data_operandB != '0) begin
              hi_d    = '0;
              lo_d    = mag_a;
              b_d     = mag_b;
              sign_d  = data_operandA[W-1] ^ data_operandB[W-1];
              dest_d  = dest_reg;
              state_d = RUN_DIV;
            end else begin
              res_d   = '0;
              exc_d   = 1'b1;
              rreg_d  = dest_reg;
              state_d = DONE;
            end
          end
        end
      end
      RUN_MUL: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          hi_d  = mul_hi;
          lo_d  = mul_lo;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last_iter) begin
            res_d   = mul_prod[W-1:0];
            exc_d   = mul_ovf;
            rreg_d  = dest_q;
            state_d = DONE;
          end
        end
      end
      RUN_DIV: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          hi_d  = div_hi;
          lo_d  = div_lo;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last_iter) begin
            res_d   = div_quot;
            exc_d   = div_ovf;
            rreg_d  = dest_q;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      dest_q  <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      dest_q  <= dest_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rreg_q  <= rreg_d;
    end
  end

  // Stall covers the start request cycle; a flush squashes the strobe immediately
  always_comb begin
    data_result    = res_q;
    data_exception = exc_q;
    result_reg     = rreg_q;
    data_resultRDY = (state_q == DONE) && !flush;
    busy           = (state_q != IDLE);
    stall          = (state_q == RUN_MUL) || (state_q == RUN_DIV) ||
                     ((state_q == IDLE) && (ctrl_MULT || ctrl_DIV));
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed testbench for multdiv_sequencer.
module tb_multdiv_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned RW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          ctrl_MULT, ctrl_DIV, flush;
  logic [W-1:0]  opa, opb;
  logic [RW-1:0] dest;
  logic [W-1:0]  data_result;
  logic          data_exception, data_resultRDY, stall, busy;
  logic [RW-1:0] result_reg;

  int checks = 0;
  int errors = 0;

  multdiv_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .flush          (flush),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .dest_reg       (dest),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .result_reg     (result_reg),
    .stall          (stall),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Issue one request, then wait (bounded) for the result strobe.
  // lat = edges after the start edge until strobe; st = cycles with stall high.
  task automatic run_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] dst, output int lat, output int st);
    @(posedge clock); #1;
    ctrl_MULT = m; ctrl_DIV = d; opa = a; opb = b; dest = dst;
    #1;
    st = (stall === 1'b1) ? 1 : 0;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    opa = 32'hDEAD_BEEF; opb = 32'h1234_5678; dest = '0;
    lat = 0;
    while (data_resultRDY !== 1'b1 && lat < 100) begin
      if (stall === 1'b1) st++;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b expected 0", data_exception); end
    checks++; if (result_reg !== 5'd0) begin errors++; $display("FAIL reset_rreg: got %0d expected 0", result_reg); end
    reset = 1'b1;
  endtask

  task automatic test_mul_basic();
    int lat, st;
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 5'd9, lat, st);
    checks++; if (lat != 32) begin errors++; $display("FAIL mul_latency: got %0d expected 32", lat); end
    checks++; if (st != 33) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected 33", st); end
    checks++; if (data_result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_result: got %h expected ffffffd6", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL mul_exc: got %b expected 0", data_exception); end
    checks++; if (result_reg !== 5'd9) begin errors++; $display("FAIL mul_rreg: got %0d expected 9", result_reg); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_done_stall: got %b expected 0", stall); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_done_busy: got %b expected 1", busy); end
    @(posedge clock); #1;
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL mul_rdy_one_cycle: got %b expected 0", data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_idle_busy: got %b expected 0", busy); end
    checks++; if (data_result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_result_hold: got %h expected ffffffd6", data_result); end
  endtask

  task automatic test_div();
    int lat, st;
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd3, lat, st);
    checks++; if (lat != 32) begin errors++; $display("FAIL div_latency: got %0d expected 32", lat); end
    checks++; if (data_result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_pos_neg: got %h expected fffffff2", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL div_pos_neg_exc: got %b expected 0", data_exception); end
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd4, lat, st);
    checks++; if (data_result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_neg_pos: got %h expected fffffff2", data_result); end
    checks++; if (result_reg !== 5'd4) begin errors++; $display("FAIL div_rreg: got %0d expected 4", result_reg); end
    run_op(1'b0, 1'b1, 32'd1000, 32'd3, 5'd6, lat, st);
    checks++; if (data_result !== 32'd333) begin errors++; $display("FAIL div_trunc: got %h expected 0000014d", data_result); end
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, lat, st);
    checks++; if (data_result !== 32'h8000_0000) begin errors++; $display("FAIL div_min_neg1: got %h expected 80000000", data_result); end
    checks++; if (data_exception !== 1'b1) begin errors++; $display("FAIL div_min_neg1_exc: got %b expected 1", data_exception); end
  endtask

  task automatic test_div_zero();
    int lat, st;
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 5'd12, lat, st);
    checks++; if (lat != 0) begin errors++; $display("FAIL divz_latency: got %0d expected 0", lat); end
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL divz_result: got %h expected 0", data_result); end
    checks++; if (data_exception !== 1'b1) begin errors++; $display("FAIL divz_exc: got %b expected 1", data_exception); end
    checks++; if (result_reg !== 5'd12) begin errors++; $display("FAIL divz_rreg: got %0d expected 12", result_reg); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL divz_stall: got %b expected 0", stall); end
    @(posedge clock); #1;
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL divz_rdy_drop: got %b expected 0", data_resultRDY); end
  endtask

  task automatic test_mul_overflow();
    int lat, st;
    run_op(1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd1, lat, st);
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL mulovf_result: got %h expected 0", data_result); end
    checks++; if (data_exception !== 1'b1) begin errors++; $display("FAIL mulovf_exc: got %b expected 1", data_exception); end
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, st);
    checks++; if (data_result !== 32'd1) begin errors++; $display("FAIL mul_negneg: got %h expected 00000001", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL mul_negneg_exc: got %b expected 0", data_exception); end
  endtask

  task automatic test_flush();
    int lat, st;
    // Flush while idle suppresses a simultaneous start
    @(posedge clock); #1;
    ctrl_MULT = 1'b1; opa = 32'd9; opb = 32'd9; flush = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b expected 0", busy); end
    // Flush mid-multiply
    ctrl_MULT = 1'b1; opa = 32'd123; opb = 32'd456; dest = 5'd7;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b expected 1", busy); end
    flush = 1'b1;
    #1;
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL flush_rdy: got %b expected 0", data_resultRDY); end
    @(posedge clock); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    run_op(1'b1, 1'b0, 32'd3, 32'd5, 5'd2, lat, st);
    checks++; if (lat != 32) begin errors++; $display("FAIL flush_next_latency: got %0d expected 32", lat); end
    checks++; if (data_result !== 32'd15) begin errors++; $display("FAIL flush_next_result: got %h expected 0000000f", data_result); end
    checks++; if (result_reg !== 5'd2) begin errors++; $display("FAIL flush_next_rreg: got %0d expected 2", result_reg); end
  endtask

  task automatic test_reset_mid();
    int lat, st;
    @(posedge clock); #1;
    ctrl_DIV = 1'b1; opa = 32'd1000; opb = 32'd3; dest = 5'd5;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", data_result); end
    checks++; if (result_reg !== 5'd0) begin errors++; $display("FAIL rstmid_rreg: got %0d expected 0", result_reg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL rstmid_rdy: got %b expected 0", data_resultRDY); end
    reset = 1'b1;
    run_op(1'b1, 1'b1, 32'd6, 32'd2, 5'd8, lat, st);
    checks++; if (lat != 32) begin errors++; $display("FAIL both_latency: got %0d expected 32", lat); end
    checks++; if (data_result !== 32'd12) begin errors++; $display("FAIL both_mult_wins: got %h expected 0000000c", data_result); end
    checks++; if (result_reg !== 5'd8) begin errors++; $display("FAIL both_rreg: got %0d expected 8", result_reg); end
  endtask

  initial begin
    reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; flush = 1'b0;
    opa = '0; opb = '0; dest = '0;
    test_reset();
    test_mul_basic();
    test_div();
    test_div_zero();
    test_mul_overflow();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Iterative multiply/divide unit with its own control FSM, shared by the processor's execute stage.
- Accepts a MULT or DIV request with two 32-bit signed operands and a destination register number.
- Holds the pipeline stalled while iterating, then presents a one-cycle-valid result, exception flag and destination register to the writeback path.
- Sits beside the ALU; the processor routes mul/div opcodes here instead of to the ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- REG_ADDR_WIDTH, 5, width of destination register number.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- ctrl_MULT  input  1  start multiply; sampled only in IDLE.
- ctrl_DIV  input  1  start divide; sampled only in IDLE.
- flush  input  1  cancel in-flight operation (branch/exception squash).
- data_operandA  input  DATA_WIDTH  multiplicand / dividend, signed.
- data_operandB  input  DATA_WIDTH  multiplier / divisor, signed.
- dest_reg  input  REG_ADDR_WIDTH  writeback register for this operation.
- data_result  output  DATA_WIDTH  product low word or quotient; valid when data_resultRDY.
- data_exception  output  1  overflow / divide-by-zero; valid when data_resultRDY.
- data_resultRDY  output  1  one-cycle result-valid strobe.
- result_reg  output  REG_ADDR_WIDTH  latched dest_reg; valid when data_resultRDY.
- stall  output  1  freeze upstream pipeline stages.
- busy  output  1  state is not IDLE.

Behaviour:
- States: IDLE, RUN_MUL, RUN_DIV, DONE. Counter cnt is CNT_WIDTH bits.
- Reset (reset==0 at an edge): state IDLE, cnt 0, all outputs 0, internal operand/accumulator registers 0. Reset overrides every other input, including a mid-operation reset.
- Start edge E0 (IDLE):
  - ctrl_MULT=1: latch operand magnitudes, result sign (signA XOR signB) and dest_reg; go to RUN_MUL, cnt=0.
  - Else ctrl_DIV=1 and operandB!=0: same latching; go to RUN_DIV, cnt=0.
  - Else ctrl_DIV=1 and operandB==0: go directly to DONE with result 0 and exception 1.
  - If both ctrl_MULT and ctrl_DIV are high, MULT wins.
- RUN_MUL: unsigned shift-add, one multiplier bit per edge. RUN_DIV: unsigned restoring division, one quotient bit per edge. cnt increments each edge. The edge where cnt==DATA_WIDTH-1 performs the final iteration and moves to DONE.
- Entering DONE: apply sign to the magnitude result and register data_result, data_exception and result_reg. data_resultRDY=1 for exactly the cycle spent in DONE. The next edge returns to IDLE.
- Latency for normal mul/div: start at E0, iterations at E1..E32, data_resultRDY high in the cycle after E32 and low after E33. Divide-by-zero: data_resultRDY high in the cycle after E0.
- Arithmetic rules:
  - Multiply: full 64-bit signed product; data_result = low 32 bits; exception=1 if the product does not fit in signed 32 bits.
  - Divide: quotient truncated toward zero; remainder discarded.
  - -2^31 / -1: result 0x80000000, exception 1.
  - Divide by zero: result 0, exception 1.
- stall = (state==RUN_MUL or RUN_DIV) or (state==IDLE and (ctrl_MULT or ctrl_DIV)). stall is 0 during DONE so writeback proceeds. busy = (state != IDLE).
- ctrl_MULT/ctrl_DIV outside IDLE (including DONE) are ignored; no queuing.
- flush=1 in RUN_* or DONE: next state IDLE, data_resultRDY forced 0 in that same cycle, no writeback. flush in IDLE suppresses a simultaneous start.
- Outside DONE, data_result, data_exception and result_reg hold their last values; consumers qualify them with data_resultRDY.

Test Plan:
- MULT A=7, B=0xFFFFFFFA (-6), dest 9 -> stall high for 33 cycles from the start cycle; data_resultRDY high exactly one cycle after E32; result 0xFFFFFFD6; exception 0; result_reg 9.
- DIV A=100, B=0xFFFFFFF9 (-7) -> result 0xFFFFFFF2 (-14), exception 0, same latency as multiply. DIV A=0xFFFFFF9C (-100), B=7 -> 0xFFFFFFF2.
- DIV A=5, B=0 -> data_resultRDY in the cycle after E0, result 0, exception 1, stall low once DONE is reached.
- MULT 0x40000000 * 4 -> result 0x00000000, exception 1. DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
- MULT starts, flush pulsed at iteration 10 -> no data_resultRDY, busy 0 next cycle. A new MULT 3*5 started immediately after -> result 15 at normal latency.
- reset driven low at DIV iteration 20 -> at that edge all outputs 0 and state IDLE. Then ctrl_MULT and ctrl_DIV asserted together with A=6, B=2 -> multiply executes, result 12.
